// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet controller and its byte-event front end.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CSUM    = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam int ERR_LINE = 0;
  localparam int ERR_FMT  = 1;
  localparam int ERR_TMO  = 2;
  localparam int ERR_OVR  = 3;

  localparam logic [7:0] DEF_HDR = 8'hA5;

  // Keeps buffer address ports at least one bit wide even for a one-byte buffer.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_pkt_ctrl_if.sv
// Receiver-side byte signals and host-side packet buffer handshake for uart_pkt_ctrl.
interface uart_pkt_ctrl_if #(
  parameter int AW = 4
);
  logic [7:0]    rx_data;
  logic          rx_rdsig;
  logic          rx_dataerror;
  logic          rx_frameerror;

  logic          pkt_valid;
  logic [7:0]    pkt_len;
  logic [AW-1:0] pkt_rd_addr;
  logic [7:0]    pkt_rd_data;
  logic          pkt_ack;

  modport slave (
    input  rx_data, rx_rdsig, rx_dataerror, rx_frameerror, pkt_rd_addr, pkt_ack,
    output pkt_valid, pkt_len, pkt_rd_data
  );

  modport master (
    output rx_data, rx_rdsig, rx_dataerror, rx_frameerror, pkt_rd_addr, pkt_ack,
    input  pkt_valid, pkt_len, pkt_rd_data
  );
endinterface

// File: rtl/uart_byte_evt.sv
// Turns the receiver's byte-ready level into a one-cycle event, one cycle after it falls,
// together with the byte and line-error flag captured on that fall.
module uart_byte_evt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdsig_i,
  input  logic [7:0] data_i,
  input  logic       dataerror_i,
  input  logic       frameerror_i,
  output logic       byte_evt_o,
  output logic [7:0] byte_o,
  output logic       line_err_o
);

  logic       rdsig_q;
  logic       evt_q;
  logic [7:0] byte_q;
  logic       lerr_q;
  logic       fall;

  assign fall = rdsig_q & ~rdsig_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdsig_q <= 1'b0;
      evt_q   <= 1'b0;
      byte_q  <= 8'h00;
      lerr_q  <= 1'b0;
    end else begin
      rdsig_q <= rdsig_i;
      evt_q   <= fall;
      if (fall) begin
        byte_q <= data_i;
        lerr_q <= dataerror_i | frameerror_i;
      end
    end
  end

  assign byte_evt_o = evt_q;
  assign byte_o     = byte_q;
  assign line_err_o = lerr_q;

endmodule

// File: rtl/uart_pkt_ctrl.sv
// Frame-level controller: header hunt, length, payload, checksum, timeout and a host-read
// packet buffer released with pkt_ack.
module uart_pkt_ctrl
  import uart_pkt_pkg::*;
#(
  parameter logic [7:0] HDR         = DEF_HDR,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 2000,
  parameter int         TW          = 12,
  parameter int         AW          = addr_w(MAX_LEN)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_enable,
  uart_pkt_ctrl_if.slave bus,
  output logic [3:0]     err_pulse,
  output logic [7:0]     err_count
);

  localparam logic [2:0]    S_IDLE    = IDLE;
  localparam logic [2:0]    S_LEN     = LEN;
  localparam logic [2:0]    S_PAYLOAD = PAYLOAD;
  localparam logic [2:0]    S_CSUM    = CSUM;
  localparam logic [2:0]    S_DONE    = DONE;
  localparam logic [7:0]    MAXL      = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO       = TW'(TIMEOUT_CYC);

  logic [2:0]    state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    idx_q, idx_d;
  logic [3:0]    err_q, err_d;
  logic [7:0]    cnt_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    rd_q;
  logic [7:0]    buf_q [MAX_LEN];
  logic          wr_en;

  logic          evt_raw, evt, line_err, in_frame, tmo_hit;
  logic [7:0]    rx_byte;

  uart_byte_evt u_evt (
    .clk          (clk),
    .rst_n        (rst_n),
    .rdsig_i      (bus.rx_rdsig),
    .data_i       (bus.rx_data),
    .dataerror_i  (bus.rx_dataerror),
    .frameerror_i (bus.rx_frameerror),
    .byte_evt_o   (evt_raw),
    .byte_o       (rx_byte),
    .line_err_o   (line_err)
  );

  assign evt      = evt_raw & cfg_enable;
  assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
  // A byte arriving on the expiry cycle takes precedence over the timeout.
  assign tmo_hit  = in_frame && (tmo_q >= TMO) && !evt;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    csum_d  = csum_q;
    idx_d   = idx_q;
    err_d   = 4'b0000;
    wr_en   = 1'b0;
    if (!cfg_enable) begin
      state_d = S_IDLE;
    end else if (in_frame && evt && line_err) begin
      err_d[ERR_LINE] = 1'b1;
      state_d         = S_IDLE;
    end else if (tmo_hit) begin
      err_d[ERR_TMO] = 1'b1;
      state_d        = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (evt) begin
            if (line_err) err_d[ERR_LINE] = 1'b1;
            else if (rx_byte == HDR) state_d = S_LEN;
          end
        end
        S_LEN: begin
          if (evt) begin
            if (rx_byte == 8'd0 || rx_byte > MAXL) begin
              err_d[ERR_FMT] = 1'b1;
              state_d        = S_IDLE;
            end else begin
              len_d   = rx_byte;
              csum_d  = rx_byte;
              idx_d   = 8'd0;
              state_d = S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (evt) begin
            wr_en  = 1'b1;
            csum_d = csum_q + rx_byte;
            idx_d  = idx_q + 8'd1;
            if (idx_q == len_q - 8'd1) state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          if (evt) begin
            if (rx_byte == csum_q) begin
              state_d = S_DONE;
            end else begin
              err_d[ERR_FMT] = 1'b1;
              state_d        = S_IDLE;
            end
          end
        end
        S_DONE: begin
          if (evt) err_d[ERR_OVR] = 1'b1;
          if (bus.pkt_ack) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= 8'd0;
      csum_q  <= 8'd0;
      idx_q   <= 8'd0;
      err_q   <= 4'b0000;
      cnt_q   <= 8'd0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      if ((|err_d) && (cnt_q != 8'hFF)) cnt_q <= cnt_q + 8'd1;
      if (!cfg_enable || evt) tmo_q <= '0;
      else if (tmo_q != '1)   tmo_q <= tmo_q + 1'b1;
    end
  end

  // Buffer storage carries no reset; only the registered read port does.
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[idx_q[AW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_q <= 8'h00;
    else        rd_q <= buf_q[bus.pkt_rd_addr];
  end

  assign bus.pkt_valid   = (state_q == S_DONE);
  assign bus.pkt_len     = len_q;
  assign bus.pkt_rd_data = rd_q;
  assign err_pulse       = err_q;
  assign err_count       = cnt_q;

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Directed-vector bench for uart_pkt_ctrl; checksum always includes the length byte.
module tb_uart_pkt_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_enable;
  logic [3:0] err_pulse;
  logic [7:0] err_count;
  int         nVec = 0;
  int         nMiss = 0;

  uart_pkt_ctrl_if #(.AW(4)) bus ();

  uart_pkt_ctrl #(
    .HDR(8'hA5), .MAX_LEN(16), .TIMEOUT_CYC(2000), .TW(12), .AW(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_enable (cfg_enable),
    .bus        (bus),
    .err_pulse  (err_pulse),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One receiver byte: rdsig high one cycle, then low; returns with the byte event active.
  task automatic applyStimulus(input logic [7:0] data, input logic derr, input logic ferr);
    bus.rx_data       = data;
    bus.rx_dataerror  = derr;
    bus.rx_frameerror = ferr;
    bus.rx_rdsig      = 1'b1;
    @(negedge clk);
    bus.rx_rdsig = 1'b0;
    @(negedge clk);
    bus.rx_dataerror  = 1'b0;
    bus.rx_frameerror = 1'b0;
  endtask

  task automatic sendFrame(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) applyStimulus(bytes[8*(n-1-i) +: 8], 1'b0, 1'b0);
  endtask

  task automatic readBuf(input logic [3:0] a, input logic [7:0] exp, input string tag);
    bus.pkt_rd_addr = a;
    @(negedge clk);
    checkOutput(tag, 32'(bus.pkt_rd_data), 32'(exp));
  endtask

  task automatic ackPkt();
    bus.pkt_ack = 1'b1;
    @(negedge clk);
    bus.pkt_ack = 1'b0;
    checkOutput("ack_valid", 32'(bus.pkt_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         first;
    logic [3:0] seen;

    rst_n             = 1'b0;
    cfg_enable        = 1'b1;
    bus.rx_data       = 8'h00;
    bus.rx_rdsig      = 1'b0;
    bus.rx_dataerror  = 1'b0;
    bus.rx_frameerror = 1'b0;
    bus.pkt_rd_addr   = 4'd0;
    bus.pkt_ack       = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 32'(bus.pkt_valid), 32'd0);
    checkOutput("rst_len", 32'(bus.pkt_len), 32'd0);
    checkOutput("rst_rdata", 32'(bus.pkt_rd_data), 32'd0);
    checkOutput("rst_err", 32'(err_pulse), 32'd0);
    checkOutput("rst_cnt", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] good frame");
    sendFrame(64'hA5_03_11_22_33_69, 6);
    checkOutput("good_valid_early", 32'(bus.pkt_valid), 32'd0);
    @(negedge clk);
    checkOutput("good_valid", 32'(bus.pkt_valid), 32'd1);
    checkOutput("good_len", 32'(bus.pkt_len), 32'd3);
    readBuf(4'd0, 8'h11, "good_rd0");
    readBuf(4'd1, 8'h22, "good_rd1");
    readBuf(4'd2, 8'h33, "good_rd2");
    ackPkt();
    checkOutput("good_cnt", 32'(err_count), 32'd0);

    $display("[TB] bad checksum");
    sendFrame(64'hA5_02_10_20_31, 5);
    @(negedge clk);
    checkOutput("badcs_err", 32'(err_pulse), 32'h2);
    checkOutput("badcs_cnt", 32'(err_count), 32'd1);
    checkOutput("badcs_valid", 32'(bus.pkt_valid), 32'd0);
    @(negedge clk);
    checkOutput("badcs_pulse_end", 32'(err_pulse), 32'h0);
    sendFrame(64'hA5_01_7F_80, 4);
    @(negedge clk);
    checkOutput("after_bad_valid", 32'(bus.pkt_valid), 32'd1);
    checkOutput("after_bad_len", 32'(bus.pkt_len), 32'd1);
    readBuf(4'd0, 8'h7F, "after_bad_rd0");
    ackPkt();

    $display("[TB] line error");
    sendFrame(64'h00_FF, 2);
    @(negedge clk);
    checkOutput("garbage_err", 32'(err_pulse), 32'h0);
    checkOutput("garbage_cnt", 32'(err_count), 32'd1);
    sendFrame(64'hA5_02, 2);
    applyStimulus(8'h55, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("line_err", 32'(err_pulse), 32'h1);
    checkOutput("line_cnt", 32'(err_count), 32'd2);
    sendFrame(64'hA5_01_05_06, 4);
    @(negedge clk);
    checkOutput("line_resync_valid", 32'(bus.pkt_valid), 32'd1);
    ackPkt();

    $display("[TB] timeout");
    sendFrame(64'hA5_04_11, 3);
    first = 0;
    seen  = 4'h0;
    for (int k = 1; k <= 2100; k++) begin
      @(negedge clk);
      if (first == 0 && err_pulse != 4'h0) begin
        first = k;
        seen  = err_pulse;
      end
    end
    checkOutput("tmo_cycle", 32'(first), 32'd2002);
    checkOutput("tmo_err", 32'(seen), 32'h4);
    checkOutput("tmo_cnt", 32'(err_count), 32'd3);

    $display("[TB] byte on timeout cycle");
    sendFrame(64'hA5_04_11, 3);
    repeat (1999) @(negedge clk);
    applyStimulus(8'h22, 1'b0, 1'b0);
    sendFrame(64'h33_44_AE, 3);
    @(negedge clk);
    checkOutput("tmo_race_valid", 32'(bus.pkt_valid), 32'd1);
    checkOutput("tmo_race_len", 32'(bus.pkt_len), 32'd4);
    checkOutput("tmo_race_cnt", 32'(err_count), 32'd3);

    $display("[TB] overrun");
    applyStimulus(8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ovr_err", 32'(err_pulse), 32'h8);
    checkOutput("ovr_cnt", 32'(err_count), 32'd4);
    checkOutput("ovr_valid", 32'(bus.pkt_valid), 32'd1);
    checkOutput("ovr_len", 32'(bus.pkt_len), 32'd4);
    readBuf(4'd0, 8'h11, "ovr_rd0");
    readBuf(4'd3, 8'h44, "ovr_rd3");
    ackPkt();

    $display("[TB] length limits");
    sendFrame(64'hA5_00, 2);
    @(negedge clk);
    checkOutput("len0_err", 32'(err_pulse), 32'h2);
    sendFrame(64'hA5_11, 2);
    @(negedge clk);
    checkOutput("len17_err", 32'(err_pulse), 32'h2);
    checkOutput("len_cnt", 32'(err_count), 32'd6);
    sendFrame(64'hA5_10, 2);
    for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1'b0, 1'b0);
    applyStimulus(8'h88, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("len16_valid", 32'(bus.pkt_valid), 32'd1);
    checkOutput("len16_len", 32'(bus.pkt_len), 32'd16);
    readBuf(4'd15, 8'h0F, "len16_rd15");
    ackPkt();

    $display("[TB] disable mid-payload");
    sendFrame(64'hA5_03_01, 3);
    cfg_enable = 1'b0;
    applyStimulus(8'h02, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("dis_err", 32'(err_pulse), 32'h0);
    checkOutput("dis_cnt", 32'(err_count), 32'd6);
    cfg_enable = 1'b1;
    sendFrame(64'h03_09, 2);
    @(negedge clk);
    checkOutput("dis_valid", 32'(bus.pkt_valid), 32'd0);
    checkOutput("dis_cnt2", 32'(err_count), 32'd6);
    sendFrame(64'hA5_02_AA_55_01, 5);
    @(negedge clk);
    checkOutput("reen_valid", 32'(bus.pkt_valid), 32'd1);
    readBuf(4'd1, 8'h55, "reen_rd1");

    $display("[TB] reset while holding a packet");
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mrst_valid", 32'(bus.pkt_valid), 32'd0);
    checkOutput("mrst_len", 32'(bus.pkt_len), 32'd0);
    checkOutput("mrst_rdata", 32'(bus.pkt_rd_data), 32'd0);
    checkOutput("mrst_cnt", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    sendFrame(64'hA5_02_11, 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sendFrame(64'h22_35, 2);
    @(negedge clk);
    checkOutput("partial_valid", 32'(bus.pkt_valid), 32'd0);
    checkOutput("partial_cnt", 32'(err_count), 32'd0);

    $display("[TB] error counter saturation");
    for (int k = 0; k < 10; k++) sendFrame(64'hA5_01_00_00, 4);
    @(negedge clk);
    checkOutput("cnt10", 32'(err_count), 32'd10);
    for (int k = 0; k < 246; k++) sendFrame(64'hA5_01_00_00, 4);
    @(negedge clk);
    checkOutput("cnt_sat", 32'(err_count), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
